// File: rtl/fwd_bypass_unit_if.sv
// fwd_bypass_unit_if: decode/stage bundle for fwd_bypass_unit.
//   master drives decode, read-port and stage-result inputs and observes operands, hit, stall, scoreboard.
//   slave is the bypass unit itself.
//   With FWD_STATS_EN defined the bundle also carries the stall/forward statistics counters.
interface fwd_bypass_unit_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH = 3,
  parameter int NREAD = 2
);
  localparam int SW = $clog2(DEPTH + 1);
  logic id_valid_i;
  logic id_wen_i;
  logic [REG_AW-1:0] id_dst_i;
  logic [SW-1:0] id_rdy_i;
  logic [NREAD-1:0] rd_en_i;
  logic [NREAD*REG_AW-1:0] rd_addr_i;
  logic [NREAD*DATA_W-1:0] rf_data_i;
  logic [DEPTH*DATA_W-1:0] stage_data_i;
  logic hold_i;
  logic flush_i;
  logic [NREAD*DATA_W-1:0] fwd_data_o;
  logic [NREAD-1:0] fwd_hit_o;
  logic stall_o;
  logic [DEPTH-1:0] sb_valid_o;
`ifdef FWD_STATS_EN
  logic [15:0] stat_stall_cyc_o;
  logic [15:0] stat_fwd_cnt_o;
`endif
  modport master (
`ifdef FWD_STATS_EN
    input stat_stall_cyc_o, input stat_fwd_cnt_o,
`endif
    output id_valid_i, output id_wen_i, output id_dst_i, output id_rdy_i,
    output rd_en_i, output rd_addr_i, output rf_data_i, output stage_data_i,
    output hold_i, output flush_i,
    input fwd_data_o, input fwd_hit_o, input stall_o, input sb_valid_o
  );
  modport slave (
`ifdef FWD_STATS_EN
    output stat_stall_cyc_o, output stat_fwd_cnt_o,
`endif
    input id_valid_i, input id_wen_i, input id_dst_i, input id_rdy_i,
    input rd_en_i, input rd_addr_i, input rf_data_i, input stage_data_i,
    input hold_i, input flush_i,
    output fwd_data_o, output fwd_hit_o, output stall_o, output sb_valid_o
  );
endinterface

// File: rtl/fwd_bypass_unit.sv
// fwd_bypass_unit: scoreboard-driven operand bypass and hazard stall for the pipelined MIPS core.
//   clk, reset (async, active-high); bus (fwd_bypass_unit_if.slave) carries decode insert, read ports,
//   register-file and stage result data in, forwarded operands, hit flags, stall and scoreboard valids out.
//   Optional statistics counters when FWD_STATS_EN is defined.
module fwd_bypass_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH = 3,
  parameter int NREAD = 2
) (
  input logic clk,
  input logic reset,
  fwd_bypass_unit_if.slave bus
);
  localparam int SW = $clog2(DEPTH + 1);
  logic [DEPTH:1] v_q, v_d;
  logic [REG_AW-1:0] dst_q [1:DEPTH];
  logic [REG_AW-1:0] dst_d [1:DEPTH];
  logic [SW-1:0] rdy_q [1:DEPTH];
  logic [SW-1:0] rdy_d [1:DEPTH];
  logic [NREAD*DATA_W-1:0] fwd_data;
  logic [NREAD-1:0] fwd_hit, port_stall;
  logic [REG_AW-1:0] a;
  logic found, stall, ins;
  logic [SW-1:0] rdy_in;
  // Scan from youngest (k=1) outward; the first match decides, so an older ready copy never leaks through.
  always_comb begin
    fwd_data = bus.rf_data_i;
    fwd_hit = '0;
    port_stall = '0;
    found = 1'b0;
    a = '0;
    for (int i = 0; i < NREAD; i++) begin
      found = 1'b0;
      a = bus.rd_addr_i[i*REG_AW +: REG_AW];
      for (int k = 1; k <= DEPTH; k++) begin
        if (!found && bus.rd_en_i[i] && a != '0 && v_q[k] && dst_q[k] == a) begin
          found = 1'b1;
          if (SW'(k) >= rdy_q[k]) begin
            fwd_hit[i] = 1'b1;
            fwd_data[i*DATA_W +: DATA_W] = bus.stage_data_i[(k-1)*DATA_W +: DATA_W];
          end else begin
            port_stall[i] = 1'b1;
          end
        end
      end
    end
  end
  assign stall = |port_stall;
  assign ins = bus.id_valid_i & bus.id_wen_i & (bus.id_dst_i != '0);
  assign rdy_in = (bus.id_rdy_i == '0 || bus.id_rdy_i > SW'(DEPTH)) ? SW'(DEPTH) : bus.id_rdy_i;
  always_comb begin
    v_d = v_q;
    dst_d = dst_q;
    rdy_d = rdy_q;
    if (bus.hold_i) begin
      v_d[1] = v_q[1] & ~bus.flush_i;
    end else begin
      for (int k = 2; k <= DEPTH; k++) begin
        v_d[k] = v_q[k-1];
        dst_d[k] = dst_q[k-1];
        rdy_d[k] = rdy_q[k-1];
      end
      v_d[1] = ins & ~bus.flush_i & ~stall;
      dst_d[1] = bus.id_dst_i;
      rdy_d[1] = rdy_in;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      dst_q <= '{default: '0};
      rdy_q <= '{default: '0};
    end else begin
      v_q <= v_d;
      dst_q <= dst_d;
      rdy_q <= rdy_d;
    end
  end
  assign bus.fwd_data_o = fwd_data;
  assign bus.fwd_hit_o = fwd_hit;
  assign bus.stall_o = stall;
  assign bus.sb_valid_o = v_q;
`ifdef FWD_STATS_EN
  logic [15:0] stall_cyc_q, fwd_cnt_q;
  logic [16:0] fwd_sum;
  always_comb begin
    fwd_sum = {1'b0, fwd_cnt_q};
    for (int i = 0; i < NREAD; i++) fwd_sum = fwd_sum + 17'(fwd_hit[i]);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cyc_q <= '0;
      fwd_cnt_q <= '0;
    end else if (!bus.hold_i) begin
      if (stall && stall_cyc_q != 16'hFFFF) stall_cyc_q <= stall_cyc_q + 16'd1;
      if (!stall) fwd_cnt_q <= fwd_sum[16] ? 16'hFFFF : fwd_sum[15:0];
    end
  end
  assign bus.stat_stall_cyc_o = stall_cyc_q;
  assign bus.stat_fwd_cnt_o = fwd_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_bypass_unit.sv
// tb_fwd_bypass_unit: directed self-checking bench for fwd_bypass_unit.
module tb_fwd_bypass_unit;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int passed = 0;
  localparam logic [31:0] RF0 = 32'hAAAA0000;
  localparam logic [31:0] RF1 = 32'hBBBB0001;
  always #5 clk = ~clk;
  fwd_bypass_unit_if #(.DATA_W(32), .REG_AW(5), .DEPTH(3), .NREAD(2)) bus ();
  fwd_bypass_unit #(.DATA_W(32), .REG_AW(5), .DEPTH(3), .NREAD(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idin(input logic v, input logic [4:0] d, input logic [1:0] r);
    bus.id_valid_i = v;
    bus.id_wen_i = 1'b1;
    bus.id_dst_i = d;
    bus.id_rdy_i = r;
  endtask
  task automatic rd(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_en_i = en;
    bus.rd_addr_i = {a1, a0};
  endtask
  task automatic sd(input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] s3);
    bus.stage_data_i = {s3, s2, s1};
  endtask
  task automatic drain;
    idin(1'b0, 5'd0, 2'd0);
    rd(2'b00, 5'd0, 5'd0);
    repeat (3) tick();
  endtask
  initial begin
    reset = 1'b1;
    bus.hold_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.rf_data_i = {RF1, RF0};
    idin(1'b0, 5'd0, 2'd0);
    rd(2'b00, 5'd0, 5'd0);
    sd(32'h0, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_sb", 32'(bus.sb_valid_o), 32'h0);
    chk("rst_stall", 32'(bus.stall_o), 32'h0);
    chk("rst_hit", 32'(bus.fwd_hit_o), 32'h0);
    chk("rst_fwd0", bus.fwd_data_o[31:0], RF0);
    chk("rst_fwd1", bus.fwd_data_o[63:32], RF1);
    reset = 1'b0;
    // ALU chain: result ready at stage 2
    idin(1'b1, 5'd8, 2'd2);
    tick();
    idin(1'b0, 5'd0, 2'd0);
    rd(2'b01, 5'd8, 5'd0);
    sd(32'h11, 32'h0, 32'h0);
    #1;
    chk("alu_sb", 32'(bus.sb_valid_o), 32'h1);
    chk("alu_stall", 32'(bus.stall_o), 32'h1);
    chk("alu_hit_wait", 32'(bus.fwd_hit_o), 32'h0);
    chk("alu_fwd_wait", bus.fwd_data_o[31:0], RF0);
    tick();
    sd(32'h11, 32'h22, 32'h0);
    rd(2'b11, 5'd8, 5'd8);
    #1;
    chk("alu_stall_go", 32'(bus.stall_o), 32'h0);
    chk("alu_hit", 32'(bus.fwd_hit_o), 32'h3);
    chk("alu_fwd0", bus.fwd_data_o[31:0], 32'h22);
    chk("alu_fwd1", bus.fwd_data_o[63:32], 32'h22);
    drain();
    // Load-use: result ready at stage 3
    idin(1'b1, 5'd9, 2'd3);
    tick();
    idin(1'b0, 5'd0, 2'd0);
    rd(2'b01, 5'd9, 5'd0);
    sd(32'h0, 32'h0, 32'hDEAD);
    #1;
    chk("lu_stall1", 32'(bus.stall_o), 32'h1);
    chk("lu_sb1", 32'(bus.sb_valid_o), 32'h1);
    tick();
    chk("lu_stall2", 32'(bus.stall_o), 32'h1);
    chk("lu_sb2", 32'(bus.sb_valid_o), 32'h2);
    tick();
    chk("lu_stall3", 32'(bus.stall_o), 32'h0);
    chk("lu_hit", 32'(bus.fwd_hit_o), 32'h1);
    chk("lu_fwd", bus.fwd_data_o[31:0], 32'hDEAD);
    chk("lu_sb3", 32'(bus.sb_valid_o), 32'h4);
    drain();
    // Youngest wins: r5 ready at k=3, pending at k=1
    idin(1'b1, 5'd5, 2'd1);
    tick();
    idin(1'b0, 5'd0, 2'd0);
    tick();
    idin(1'b1, 5'd5, 2'd2);
    tick();
    idin(1'b0, 5'd0, 2'd0);
    rd(2'b01, 5'd5, 5'd0);
    sd(32'h0, 32'h55, 32'h33);
    #1;
    chk("yw_sb", 32'(bus.sb_valid_o), 32'h5);
    chk("yw_stall", 32'(bus.stall_o), 32'h1);
    chk("yw_hit", 32'(bus.fwd_hit_o), 32'h0);
    chk("yw_fwd_rf", bus.fwd_data_o[31:0], RF0);
    tick();
    chk("yw_stall_go", 32'(bus.stall_o), 32'h0);
    chk("yw_fwd", bus.fwd_data_o[31:0], 32'h55);
    chk("yw_hit_go", 32'(bus.fwd_hit_o), 32'h1);
    chk("yw_sb_go", 32'(bus.sb_valid_o), 32'h2);
    drain();
    // rdy=0 clamps to the last stage
    idin(1'b1, 5'd7, 2'd0);
    tick();
    idin(1'b0, 5'd0, 2'd0);
    rd(2'b10, 5'd0, 5'd7);
    #1;
    chk("clamp_stall1", 32'(bus.stall_o), 32'h1);
    tick();
    chk("clamp_stall2", 32'(bus.stall_o), 32'h1);
    tick();
    chk("clamp_hit", 32'(bus.fwd_hit_o), 32'h2);
    chk("clamp_fwd1", bus.fwd_data_o[63:32], 32'h33);
    drain();
    // r0 never tracked or forwarded; disabled port never stalls
    idin(1'b1, 5'd0, 2'd1);
    tick();
    idin(1'b0, 5'd0, 2'd0);
    chk("r0_sb", 32'(bus.sb_valid_o), 32'h0);
    bus.rf_data_i = {RF1, 32'h0};
    rd(2'b01, 5'd0, 5'd0);
    #1;
    chk("r0_hit", 32'(bus.fwd_hit_o), 32'h0);
    chk("r0_fwd", bus.fwd_data_o[31:0], 32'h0);
    bus.rf_data_i = {RF1, RF0};
    rd(2'b00, 5'd0, 5'd0);
    idin(1'b1, 5'd10, 2'd3);
    tick();
    idin(1'b0, 5'd0, 2'd0);
    rd(2'b00, 5'd10, 5'd0);
    #1;
    chk("rden_stall", 32'(bus.stall_o), 32'h0);
    chk("rden_hit", 32'(bus.fwd_hit_o), 32'h0);
    drain();
    // hold + flush kills entry 1 only; hold then ignores inserts
    idin(1'b1, 5'd1, 2'd1);
    tick();
    idin(1'b1, 5'd2, 2'd1);
    tick();
    idin(1'b1, 5'd3, 2'd1);
    tick();
    idin(1'b0, 5'd0, 2'd0);
    chk("hf_sb_pre", 32'(bus.sb_valid_o), 32'h7);
    bus.hold_i = 1'b1;
    bus.flush_i = 1'b1;
    tick();
    chk("hf_sb", 32'(bus.sb_valid_o), 32'h6);
    bus.flush_i = 1'b0;
    idin(1'b1, 5'd4, 2'd1);
    tick();
    chk("hold_sb", 32'(bus.sb_valid_o), 32'h6);
    bus.hold_i = 1'b0;
    idin(1'b0, 5'd0, 2'd0);
    rd(2'b11, 5'd2, 5'd1);
    sd(32'h111, 32'h222, 32'h333);
    #1;
    chk("hf_fwd0", bus.fwd_data_o[31:0], 32'h222);
    chk("hf_fwd1", bus.fwd_data_o[63:32], 32'h333);
    chk("hf_hit", 32'(bus.fwd_hit_o), 32'h3);
    drain();
    // Async reset between edges while stalled
    idin(1'b1, 5'd12, 2'd3);
    tick();
    idin(1'b0, 5'd0, 2'd0);
    rd(2'b01, 5'd12, 5'd0);
    #1;
    chk("ar_stall_pre", 32'(bus.stall_o), 32'h1);
    reset = 1'b1;
    #1;
    chk("ar_stall", 32'(bus.stall_o), 32'h0);
    chk("ar_sb", 32'(bus.sb_valid_o), 32'h0);
    chk("ar_hit", 32'(bus.fwd_hit_o), 32'h0);
    chk("ar_fwd0", bus.fwd_data_o[31:0], RF0);
`ifdef FWD_STATS_EN
    chk("st_stall_rst", 32'(bus.stat_stall_cyc_o), 32'h0);
    chk("st_fwd_rst", 32'(bus.stat_fwd_cnt_o), 32'h0);
    tick();
    reset = 1'b0;
    rd(2'b00, 5'd0, 5'd0);
    idin(1'b1, 5'd9, 2'd3);
    tick();
    idin(1'b0, 5'd0, 2'd0);
    rd(2'b01, 5'd9, 5'd0);
    tick();
    tick();
    chk("st_stall_lu", 32'(bus.stat_stall_cyc_o), 32'd2);
    chk("st_fwd_lu", 32'(bus.stat_fwd_cnt_o), 32'd0);
    tick();
    chk("st_fwd_one", 32'(bus.stat_fwd_cnt_o), 32'd1);
    idin(1'b1, 5'd20, 2'd1);
    rd(2'b11, 5'd20, 5'd20);
    repeat (33000) tick();
    chk("st_fwd_sat", 32'(bus.stat_fwd_cnt_o), 32'hFFFF);
    chk("st_stall_keep", 32'(bus.stat_stall_cyc_o), 32'd2);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fwd_bypass_unit.md
Name: fwd_bypass_unit

Overview:
- Parametrised operand-bypass and hazard unit for the pipelined MIPS core; successor to the fixed 5-stage forwarding muxes.
- Keeps a shifting scoreboard of in-flight register writes (one entry per stage after decode).
- Each cycle it picks, per decode read port, the youngest ready producer from the stage result buses, or the register-file value.
- Raises stall when the youngest producer's result is not yet available, e.g. load-use.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register address width; register 0 never forwards
DEPTH, 3, tracked stages after decode (1=E, 2=M, 3=W)
NREAD, 2, decode read ports
SW, $clog2(DEPTH+1), width of stage-index fields (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears scoreboard
id_valid  in  1  decode holds a real instruction
id_wen  in  1  decode instruction writes a register
id_dst  in  REG_AW  destination register
id_rdy  in  SW  stage index at which the result appears on stage_data (1..DEPTH)
rd_en  in  NREAD  read port i uses its operand
rd_addr  in  NREAD*REG_AW  source register per port, port i at [i*REG_AW +: REG_AW]
rf_data  in  NREAD*DATA_W  register-file read data per port
stage_data  in  DEPTH*DATA_W  result bus of stage k at [(k-1)*DATA_W +: DATA_W]
hold  in  1  global freeze (e.g. multiplier busy)
flush  in  1  kill decode instruction (branch/exception)
fwd_data  out  NREAD*DATA_W  forwarded operand per port
fwd_hit  out  NREAD  port i is served from stage_data
stall  out  1  decode must not advance
sb_valid  out  DEPTH  scoreboard entry valid flags (debug)

Behaviour:
- Entry k (1..DEPTH) holds {v, dst, rdy}. Insert condition: id_valid & id_wen & id_dst!=0. id_rdy of 0 or >DEPTH is clamped to DEPTH.
- Port i matches entry k when: rd_en[i], rd_addr[i]!=0, v_k, and dst_k==rd_addr[i]. Youngest match (smallest k) wins.
  - Winner ready (k >= rdy_k): fwd_data[i] = stage_data[k], fwd_hit[i] = 1.
  - Winner not ready: port stalls; fwd_data[i] = rf_data[i], fwd_hit[i] = 0.
  - No match: fwd_data[i] = rf_data[i], fwd_hit[i] = 0.
- Forwarding and stall are combinational (zero latency). Scoreboard updates only on the rising edge.
- stall = OR of per-port stalls. It is not gated by hold.
- Clock edge, by priority:
  - hold=1: all entries keep their values, except entry 1 is invalidated if flush=1.
  - else: entries k=2..DEPTH take entry k-1. Entry DEPTH retires.
  - Entry 1 then loads: bubble (v=0) if flush or stall; else the decode insert if its condition holds; else v=0.
- Reset, asynchronous: all v=0, dst=0, rdy=0. So sb_valid=0, stall=0, fwd_hit=0, fwd_data=rf_data.
- Reset asserted mid-stall: stall drops in the same cycle as reset.
- Same dst in several stages: the youngest wins even if an older entry is ready. This is a stall case, never a stale forward.
- Entry in stage DEPTH is always ready because of the clamp.

Optional Feature:
- Macro FWD_STATS_EN.
- Defined: adds outputs stat_stall_cyc (16) and stat_fwd_cnt (16). Both are saturating at 16'hFFFF and cleared by reset.
  - stat_stall_cyc increments each cycle with stall=1 and hold=0.
  - stat_fwd_cnt adds popcount(fwd_hit) each cycle with hold=0 and stall=0.
- Undefined: outputs and counters are absent. All other behaviour is identical.

Test Plan:
- ALU chain: cycle 0 insert dst=8, rdy=2; cycle 1 read r8, stage_data[1]=0x11 -> stall=1; cycle 2 (entry at k=2), stage_data[2]=0x22 -> fwd_data=0x22, fwd_hit=1, stall=0.
- Load-use: insert dst=9, rdy=3; next cycle read r9 -> stall=1 for 2 cycles, entry 1 receives bubbles; then fwd_data=stage_data[3]=0xDEAD, stall=0.
- Youngest wins: r5 in k=3 (ready, 0x33) and k=1 (rdy=2) -> stall=1, no forward of 0x33; next cycle -> fwd_data=stage_data[2].
- r0 and rd_en=0: dst=0 insert ignored (sb_valid[0]=0); read r0 with rf_data=0 -> fwd_hit=0, fwd_data=0; rd_en=0 on a pending reg -> stall=0.
- hold+flush: entries k=1..3 valid, hold=1, flush=1 for one edge -> sb_valid 3'b111 -> 3'b110, entries 2..3 unchanged.
- Async reset asserted between edges during stall -> stall, sb_valid, fwd_hit drop immediately; with FWD_STATS_EN counters read 0; saturation check at 16'hFFFF.
